// File: rtl/tile_mm_controller_pkg.sv
// Shared types and defaults for the tiled matrix-multiply controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package tile_mm_controller_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DIM_DEF        = 8;
  localparam int OUT_LAT_DEF    = 3;

  // One encoding shared by the main, read and write-back FSMs.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/tile_mm_controller_if.sv
// Host, A/B/P buffer and systolic-array signals of the controller.
// Latency: n/a (wires only).
// Backpressure: stall_i is carried here alongside the buffer signals.
interface tile_mm_controller_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM        = 8
);
  logic                    start_i;
  logic                    stall_i;
  logic                    valid_o;
  logic                    err_o;
  logic [ADDR_WIDTH-1:0]   m_i;
  logic [ADDR_WIDTH-1:0]   k_i;
  logic [ADDR_WIDTH-1:0]   n_i;
  logic [ADDR_WIDTH-1:0]   base_addra_i;
  logic [ADDR_WIDTH-1:0]   base_addrb_i;
  logic [ADDR_WIDTH-1:0]   base_addrp_i;
  logic                    pe_clr_o;
  logic                    pe_we_o;
  logic                    ensys_o;
  logic                    bubble_o;
  logic                    ena_o;
  logic                    enb_o;
  logic                    wea_o;
  logic                    web_o;
  logic [ADDR_WIDTH-1:0]   addra_o;
  logic [ADDR_WIDTH-1:0]   addrb_o;
  logic                    enp_o;
  logic                    wep_o;
  logic [ADDR_WIDTH-1:0]   addrp_o;
  logic [$clog2(DIM)-1:0]  wordp_sel_o;
  logic [DIM-1:0]          datap_we_o;

  // Host / buffer side.
  modport master (
    output start_i, stall_i, m_i, k_i, n_i, base_addra_i, base_addrb_i, base_addrp_i,
    input  valid_o, err_o, pe_clr_o, pe_we_o, ensys_o, bubble_o, ena_o, enb_o,
           wea_o, web_o, addra_o, addrb_o, enp_o, wep_o, addrp_o, wordp_sel_o, datap_we_o
  );

  // Controller side.
  modport slave (
    input  start_i, stall_i, m_i, k_i, n_i, base_addra_i, base_addrb_i, base_addrp_i,
    output valid_o, err_o, pe_clr_o, pe_we_o, ensys_o, bubble_o, ena_o, enb_o,
           wea_o, web_o, addra_o, addrb_o, enp_o, wep_o, addrp_o, wordp_sel_o, datap_we_o
  );

endinterface

// File: rtl/tile_mm_controller_wb_sequencer.sv
// Write-back sequencer: waits for a tile's results then writes its P columns.
// Latency: first P write OUT_LAT+tile_m cycles after load_i; then tile_n write cycles.
// Backpressure: stall_i freezes state, counters and latched geometry.
module tile_wb_sequencer
  import tile_mm_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DIM        = DIM_DEF,
  parameter int OUT_LAT    = OUT_LAT_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    stall_i,
  input  logic                    load_i,
  input  logic [$clog2(DIM):0]    tile_m_i,
  input  logic [$clog2(DIM):0]    tile_n_i,
  input  logic [ADDR_WIDTH-1:0]   base_i,
  output logic                    idle_o,
  output logic                    enp_o,
  output logic                    wep_o,
  output logic [ADDR_WIDTH-1:0]   addrp_o,
  output logic [$clog2(DIM)-1:0]  wordp_sel_o,
  output logic [DIM-1:0]          datap_we_o
);

  localparam int LD = $clog2(DIM);
  localparam int TW = LD + 1;
  localparam int CW = $clog2(OUT_LAT + DIM + 1);
  typedef logic [DIM-1:0] mask_t;

  state_e                st_q, st_d;
  logic [CW-1:0]         cnt_q, cnt_d, wait_len;
  logic [TW-1:0]         tm_q, tm_d, tn_q, tn_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LD-1:0]         j_q, j_d;
  logic                  busy;

  // Results reach the array edge OUT_LAT cycles after the last operand, then drain one row per cycle.
  assign wait_len = CW'(OUT_LAT) + CW'(tile_m_i) - CW'(1);

  // Write FSM next state; tile geometry is captured at load so the read side can move on.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    tm_d   = tm_q;
    tn_d   = tn_q;
    base_d = base_q;
    j_d    = j_q;
    case (st_q)
      ST_IDLE: begin
        if (load_i) begin
          tm_d   = tile_m_i;
          tn_d   = tile_n_i;
          base_d = base_i;
          j_d    = '0;
          if (wait_len == '0) begin
            st_d = ST_BUSY;
          end else begin
            st_d  = ST_WAIT;
            cnt_d = wait_len - CW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) st_d = ST_BUSY;
        else             cnt_d = cnt_q - CW'(1);
      end
      ST_BUSY: begin
        if ({1'b0, j_q} == tn_q - TW'(1)) st_d = ST_IDLE;
        else                             j_d  = j_q + LD'(1);
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Write FSM state and latched geometry; frozen while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      tm_q   <= '0;
      tn_q   <= '0;
      base_q <= '0;
      j_q    <= '0;
    end else if (!stall_i) begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      tm_q   <= tm_d;
      tn_q   <= tn_d;
      base_q <= base_d;
      j_q    <= j_d;
    end
  end

  assign busy        = (st_q == ST_BUSY);
  assign idle_o      = (st_q == ST_IDLE);
  assign enp_o       = busy;
  assign wep_o       = busy;
  assign addrp_o     = busy ? base_q + ADDR_WIDTH'(j_q) : '0;
  assign wordp_sel_o = busy ? j_q : '0;
  // Only rows that exist in a short last row tile get their byte lanes written.
  assign datap_we_o  = !busy ? '0 :
                       (tm_q == TW'(DIM)) ? '1 : ((mask_t'(1) << tm_q) - mask_t'(1));

endmodule

// File: rtl/tile_mm_controller.sv
// Sequences a DIMxDIM systolic array over MxK*KxN: operand reads per tile, PE control, P write-back.
// Latency: first read the cycle after start is seen; DONE once the last tile has been written.
// Backpressure: stall_i freezes every register; a busy write-back holds reads at the tile's last operand.
module tile_mm_controller
  import tile_mm_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DIM        = DIM_DEF,
  parameter int OUT_LAT    = OUT_LAT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  tile_mm_controller_if.slave bus
);

  localparam int LD = $clog2(DIM);
  localparam int TW = LD + 1;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  state_e        main_q, main_d, rd_q, rd_d;
  logic          start_q, err_q, err_d;
  addr_t         c_q, c_d, rt_q, rt_d, ct_q, ct_d;
  addr_t         a_off_q, a_off_d, b_off_q, b_off_d;
  addr_t         p_row_q, p_row_d, p_col_q, p_col_d;
  addr_t         rt_last, ct_last, tc_last, k_last, p_base;
  logic [LD-1:0] m_rem, n_rem;
  logic [TW-1:0] tile_m, tile_n;
  logic          dims_zero, start_rise, start_run;
  logic          wb_idle, rd_busy, at_k_last, hold, issue;

  // Run geometry: last tile indices avoid the overflow of a ceil-divide near 2^ADDR_WIDTH.
  assign dims_zero  = (bus.m_i == '0) || (bus.k_i == '0) || (bus.n_i == '0);
  assign start_rise = bus.start_i && !start_q;
  assign rt_last    = (bus.m_i - addr_t'(1)) >> LD;
  assign ct_last    = (bus.n_i - addr_t'(1)) >> LD;
  assign k_last     = bus.k_i - addr_t'(1);
  assign tc_last    = (bus.k_i > addr_t'(DIM)) ? k_last : addr_t'(DIM - 1);
  assign m_rem      = bus.m_i[LD-1:0];
  assign n_rem      = bus.n_i[LD-1:0];
  assign tile_m     = (rt_q != rt_last || m_rem == '0) ? TW'(DIM) : {1'b0, m_rem};
  assign tile_n     = (ct_q != ct_last || n_rem == '0) ? TW'(DIM) : {1'b0, n_rem};
  assign p_base     = bus.base_addrp_i + p_row_q + p_col_q;

  // Interlock: the last real operand waits until the previous tile has left the write-back.
  assign rd_busy   = (rd_q == ST_BUSY);
  assign at_k_last = (c_q == k_last);
  assign hold      = rd_busy && at_k_last && !wb_idle;
  assign issue     = rd_busy && !hold;

  // Main FSM next state and error flag.
  always_comb begin
    main_d    = main_q;
    err_d     = err_q;
    start_run = 1'b0;
    case (main_q)
      ST_IDLE: begin
        if (start_rise) begin
          if (dims_zero) begin
            main_d = ST_DONE;
            err_d  = 1'b1;
          end else begin
            main_d    = ST_BUSY;
            err_d     = 1'b0;
            start_run = 1'b1;
          end
        end
      end
      ST_BUSY: if (rd_q == ST_DONE && wb_idle) main_d = ST_DONE;
      ST_DONE: begin
        if (!bus.start_i) begin
          main_d = ST_IDLE;
          err_d  = 1'b0;
        end
      end
      default: main_d = ST_IDLE;
    endcase
  end

  // Read FSM and tile counters; offsets accumulate so no multiplier is needed.
  always_comb begin
    rd_d    = rd_q;
    c_d     = c_q;
    rt_d    = rt_q;
    ct_d    = ct_q;
    a_off_d = a_off_q;
    b_off_d = b_off_q;
    p_row_d = p_row_q;
    p_col_d = p_col_q;
    case (rd_q)
      ST_IDLE: begin
        c_d = '0; rt_d = '0; ct_d = '0;
        a_off_d = '0; b_off_d = '0; p_row_d = '0; p_col_d = '0;
        if (start_run) rd_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (issue) begin
          if (c_q == tc_last) begin
            c_d = '0;
            if (ct_q == ct_last) begin
              ct_d = '0; b_off_d = '0; p_col_d = '0;
              if (rt_q == rt_last) begin
                rd_d = ST_DONE;
              end else begin
                rt_d    = rt_q + addr_t'(1);
                a_off_d = a_off_q + bus.k_i;
                p_row_d = p_row_q + bus.n_i;
              end
            end else begin
              ct_d    = ct_q + addr_t'(1);
              b_off_d = b_off_q + bus.k_i;
              p_col_d = p_col_q + addr_t'(DIM);
            end
          end else begin
            c_d = c_q + addr_t'(1);
          end
        end
      end
      ST_DONE: begin
        // Main reaches DONE only after this FSM, so returning here keeps the two in step.
        if (main_q == ST_DONE) begin
          rd_d = ST_IDLE;
          c_d = '0; rt_d = '0; ct_d = '0;
          a_off_d = '0; b_off_d = '0; p_row_d = '0; p_col_d = '0;
        end
      end
      default: rd_d = ST_IDLE;
    endcase
  end

  // Controller state registers; nothing moves while the buffers stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q  <= ST_IDLE;
      rd_q    <= ST_IDLE;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      c_q     <= '0;
      rt_q    <= '0;
      ct_q    <= '0;
      a_off_q <= '0;
      b_off_q <= '0;
      p_row_q <= '0;
      p_col_q <= '0;
    end else if (!bus.stall_i) begin
      main_q  <= main_d;
      rd_q    <= rd_d;
      start_q <= bus.start_i;
      err_q   <= err_d;
      c_q     <= c_d;
      rt_q    <= rt_d;
      ct_q    <= ct_d;
      a_off_q <= a_off_d;
      b_off_q <= b_off_d;
      p_row_q <= p_row_d;
      p_col_q <= p_col_d;
    end
  end

  assign bus.valid_o  = (main_q == ST_DONE);
  assign bus.err_o    = (main_q == ST_DONE) && err_q;
  assign bus.ena_o    = issue;
  assign bus.enb_o    = issue;
  assign bus.ensys_o  = issue;
  assign bus.wea_o    = 1'b0;
  assign bus.web_o    = 1'b0;
  assign bus.pe_clr_o = issue && (c_q == '0);
  assign bus.pe_we_o  = issue && at_k_last;
  assign bus.bubble_o = issue && (c_q >= bus.k_i);
  assign bus.addra_o  = issue ? bus.base_addra_i + a_off_q + c_q : '0;
  assign bus.addrb_o  = issue ? bus.base_addrb_i + b_off_q + c_q : '0;

  tile_wb_sequencer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM        (DIM),
    .OUT_LAT    (OUT_LAT)
  ) u_wb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .stall_i     (bus.stall_i),
    .load_i      (bus.pe_we_o),
    .tile_m_i    (tile_m),
    .tile_n_i    (tile_n),
    .base_i      (p_base),
    .idle_o      (wb_idle),
    .enp_o       (bus.enp_o),
    .wep_o       (bus.wep_o),
    .addrp_o     (bus.addrp_o),
    .wordp_sel_o (bus.wordp_sel_o),
    .datap_we_o  (bus.datap_we_o)
  );

endmodule

// File: tb/tb_tile_mm_controller.sv
// Scoreboard bench for tile_mm_controller: a reference model queues expected reads/writes per run,
// a negedge monitor pops and compares every non-stalled operand read and P write.
module tb_tile_mm_controller;

  localparam int AW      = 16;
  localparam int DIM     = 8;
  localparam int OUT_LAT = 3;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        clr;
    logic        we;
    logic        bub;
  } rd_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [2:0]  sel;
    logic [7:0]  mask;
    logic        first;
    logic        last;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_mm_controller_if #(.ADDR_WIDTH(AW), .DIM(DIM)) bus ();

  tile_mm_controller #(.ADDR_WIDTH(AW), .DIM(DIM), .OUT_LAT(OUT_LAT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int  checks = 0;
  int  failures = 0;
  rd_t rd_q[$];
  wr_t wr_q[$];
  int  lat_q[$];
  int  due_q[$];
  int  outstanding = 0;
  int  ncyc = 0;
  bit  stall_en = 0;
  int  stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic flush();
    rd_q.delete(); wr_q.delete(); lat_q.delete(); due_q.delete();
    outstanding = 0;
  endtask

  // Reference model: every operand read and P write of the run, in issue order.
  task automatic build_model(input int m, input int k, input int n,
                             input int ba, input int bb, input int bp);
    int rtn, ctn, tc, tm, tn;
    rd_t e;
    wr_t w;
    rtn = (m + DIM - 1) / DIM;
    ctn = (n + DIM - 1) / DIM;
    tc  = (k > DIM) ? k : DIM;
    for (int rt = 0; rt < rtn; rt++) begin
      for (int ct = 0; ct < ctn; ct++) begin
        tm = (rt == rtn - 1 && (m % DIM) != 0) ? (m % DIM) : DIM;
        tn = (ct == ctn - 1 && (n % DIM) != 0) ? (n % DIM) : DIM;
        for (int c = 0; c < tc; c++) begin
          e.a   = 16'(ba + rt * k + c);
          e.b   = 16'(bb + ct * k + c);
          e.clr = (c == 0);
          e.we  = (c == k - 1);
          e.bub = (c >= k);
          rd_q.push_back(e);
        end
        lat_q.push_back(OUT_LAT + tm);
        for (int j = 0; j < tn; j++) begin
          w.addr  = 16'(bp + rt * n + ct * DIM + j);
          w.sel   = 3'(j);
          w.mask  = 8'((1 << tm) - 1);
          w.first = (j == 0);
          w.last  = (j == tn - 1);
          wr_q.push_back(w);
        end
      end
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.valid_o, bus.err_o, bus.pe_clr_o, bus.pe_we_o, bus.ensys_o, bus.bubble_o,
            bus.ena_o, bus.enb_o, bus.enp_o, bus.wep_o, bus.datap_we_o, bus.wordp_sel_o,
            (bus.addra_o | bus.addrb_o | bus.addrp_o)};
  endfunction

  // Back-pressure generator: bursts of three stalled cycles.
  initial begin
    bus.stall_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        bus.stall_i = 1'b1;
        stall_cnt--;
      end else if (stall_en && $urandom_range(0, 11) == 0) begin
        bus.stall_i = 1'b1;
        stall_cnt = 2;
      end else begin
        bus.stall_i = 1'b0;
      end
    end
  end

  // Monitor: compares each transferred read/write against the model queues.
  initial begin
    rd_t e;
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst_n && !bus.stall_i) begin
        chk("wea_web_zero", {bus.wea_o, bus.web_o}, 0);
        if (bus.ena_o | bus.enb_o | bus.ensys_o | bus.pe_clr_o | bus.pe_we_o | bus.bubble_o) begin
          if (rd_q.size() == 0) begin
            chk("unexpected_read", bus.addra_o, 64'hDEAD);
          end else begin
            e = rd_q.pop_front();
            chk("read_op",
                {bus.ena_o, bus.enb_o, bus.ensys_o, bus.addra_o, bus.addrb_o,
                 bus.pe_clr_o, bus.pe_we_o, bus.bubble_o},
                {3'b111, e.a, e.b, e.clr, e.we, e.bub});
          end
          if (bus.pe_we_o) begin
            chk("interlock_outstanding", outstanding, 0);
            outstanding++;
            if (lat_q.size() > 0) due_q.push_back(ncyc + lat_q.pop_front());
          end
        end else begin
          chk("read_idle_addr", {bus.addra_o, bus.addrb_o}, 0);
        end
        if (bus.enp_o | bus.wep_o) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_write", bus.addrp_o, 64'hDEAD);
          end else begin
            w = wr_q.pop_front();
            chk("p_write",
                {bus.enp_o, bus.wep_o, bus.addrp_o, bus.wordp_sel_o, bus.datap_we_o},
                {2'b11, w.addr, w.sel, w.mask});
            if (w.first && due_q.size() > 0) chk("p_first_latency", ncyc, due_q.pop_front());
            if (w.last) outstanding--;
          end
        end else begin
          chk("p_idle_mask", bus.datap_we_o, 0);
        end
        ncyc++;
      end
    end
  end

  task automatic run(input int m, input int k, input int n, input int ba, input int bb,
                     input int bp, input bit st, input bit drop);
    bit exp_err;
    int seen;
    exp_err = (m == 0 || k == 0 || n == 0);
    seen = -1;
    if (!exp_err) build_model(m, k, n, ba, bb, bp);
    @(posedge clk); #1;
    bus.m_i = 16'(m); bus.k_i = 16'(k); bus.n_i = 16'(n);
    bus.base_addra_i = 16'(ba); bus.base_addrb_i = 16'(bb); bus.base_addrp_i = 16'(bp);
    stall_en = st;
    bus.start_i = 1'b1;
    for (int cyc = 0; cyc < 6000 && seen < 0; cyc++) begin
      @(negedge clk);
      if (bus.valid_o) seen = cyc;
      if (drop && cyc == 3) bus.start_i = 1'b0;
    end
    chk("run_done", (seen >= 0), 1);
    if (seen >= 0) begin
      chk("err_flag", bus.err_o, exp_err);
      if (exp_err) chk("err_done_latency", seen, 1);
    end
    chk("reads_left", rd_q.size(), 0);
    chk("writes_left", wr_q.size(), 0);
    stall_en = 0;
    bus.start_i = 1'b0;
    for (int cyc = 0; cyc < 20 && bus.valid_o; cyc++) @(negedge clk);
    chk("back_to_idle", bus.valid_o, 0);
    flush();
  endtask

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    bus.start_i = 1'b0;
    bus.m_i = '0; bus.k_i = '0; bus.n_i = '0;
    bus.base_addra_i = '0; bus.base_addrb_i = '0; bus.base_addrp_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;

    run(8, 8, 8, 0, 0, 0, 0, 0);
    run(10, 4, 3, 16'h0040, 16'h0080, 16'h0100, 0, 0);
    run(10, 4, 3, 16'h0040, 16'h0080, 16'h0100, 1, 0);
    run(5, 1, 24, 16'h0010, 16'h0020, 16'h0300, 0, 1);
    run(8, 0, 8, 16'h0001, 16'h0002, 16'h0003, 0, 0);
    run(0, 3, 3, 16'h0001, 16'h0002, 16'h0003, 0, 1);
    run(17, 9, 19, 16'hFFF0, 16'hFFF8, 16'hFFFA, 1, 1);

    // Reset in the middle of write-back, then a clean rerun.
    build_model(8, 8, 8, 100, 200, 300);
    @(posedge clk); #1;
    bus.m_i = 16'd8; bus.k_i = 16'd8; bus.n_i = 16'd8;
    bus.base_addra_i = 16'd100; bus.base_addrb_i = 16'd200; bus.base_addrp_i = 16'd300;
    bus.start_i = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 500 && !got; cyc++) begin
      @(negedge clk);
      if (bus.enp_o) got = 1;
    end
    chk("reached_write", got, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_write_outputs", all_outs(), 0);
    flush();
    bus.start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(8, 8, 8, 100, 200, 300, 0, 0);

    for (int i = 0; i < 10; i++) begin
      run($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 20),
          $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
